// File: rtl/instr_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches, tracks in-flight
// requests, and presents returned instructions through a show-ahead FIFO.
module instr_prefetch_buffer #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   occ_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fifo_entry_t;

  localparam cnt_t        ONE_C     = cnt_t'(1);
  localparam ptr_t        ONE_P     = ptr_t'(1);
  localparam occ_t        DEPTH_OCC = occ_t'(DEPTH);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Architectural state
  logic [31:0] fetch_pc_q,     fetch_pc_d;
  ptr_t        fifo_head_q,    fifo_head_d;
  ptr_t        fifo_tail_q,    fifo_tail_d;
  cnt_t        fifo_count_q,   fifo_count_d;
  ptr_t        inflight_head_q, inflight_head_d;
  ptr_t        inflight_tail_q, inflight_tail_d;
  cnt_t        outstanding_q,  outstanding_d;
  cnt_t        discard_q,      discard_d;

  fifo_entry_t fifo_mem_q     [DEPTH];
  logic [31:0] inflight_mem_q [DEPTH];

  // Per-cycle control
  occ_t        occupancy;
  logic        grant;
  logic        drop;
  logic        keep;
  logic        fifo_push;
  logic        fifo_pop;
  fifo_entry_t fifo_wr_data;
  fifo_entry_t head_entry;

  always_comb begin
    occupancy = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
    imem_req  = resetn && !redirect && (occupancy < DEPTH_OCC);
    imem_addr = fetch_pc_q;
    grant     = imem_req && imem_gnt;
    drop      = imem_rvalid && (discard_q != '0);
    keep      = imem_rvalid && !drop;
    // A redirect flushes the FIFO, so neither side of it may move that cycle.
    fifo_push = keep && !redirect;
    fifo_pop  = instr_valid && instr_ready && !redirect;

    fifo_wr_data.instr = imem_rdata;
    fifo_wr_data.pc    = inflight_mem_q[inflight_head_q];
  end

  always_comb begin
    head_entry   = fifo_mem_q[fifo_head_q];
    instr_valid  = (fifo_count_q != '0);
    instr_out    = instr_valid ? head_entry.instr : NOP_INSTR;
    pc_out       = instr_valid ? head_entry.pc    : 32'h0000_0000;
    pc_plus4_out = pc_out + 32'd4;
  end

  // NOTE: every signal gets a default at the top of the block, so no path
  // through the conditionals can leave one unassigned and infer a latch.
  always_comb begin
    fetch_pc_d      = fetch_pc_q;
    fifo_head_d     = fifo_head_q;
    fifo_tail_d     = fifo_tail_q;
    fifo_count_d    = fifo_count_q;
    inflight_head_d = inflight_head_q;
    inflight_tail_d = inflight_tail_q;
    outstanding_d   = outstanding_q;
    discard_d       = discard_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (grant) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    unique case ({grant, imem_rvalid})
      2'b10:   outstanding_d = outstanding_q + ONE_C;
      2'b01:   outstanding_d = outstanding_q - ONE_C;
      default: ;
    endcase

    // Everything still in flight at a redirect (bar a response landing now)
    // belongs to the old path; re-deriving from outstanding makes
    // back-to-back redirects accumulate without extra bookkeeping.
    if (redirect) begin
      discard_d = imem_rvalid ? (outstanding_q - ONE_C) : outstanding_q;
    end else if (drop) begin
      discard_d = discard_q - ONE_C;
    end

    if (redirect) begin
      inflight_head_d = inflight_tail_q;
    end else if (keep) begin
      inflight_head_d = inflight_head_q + ONE_P;
    end
    if (grant) begin
      inflight_tail_d = inflight_tail_q + ONE_P;
    end

    if (redirect) begin
      fifo_head_d  = '0;
      fifo_tail_d  = '0;
      fifo_count_d = '0;
    end else begin
      if (fifo_push) begin
        fifo_tail_d = fifo_tail_q + ONE_P;
      end
      if (fifo_pop) begin
        fifo_head_d = fifo_head_q + ONE_P;
      end
      unique case ({fifo_push, fifo_pop})
        2'b10:   fifo_count_d = fifo_count_q + ONE_C;
        2'b01:   fifo_count_d = fifo_count_q - ONE_C;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q      <= RESET_PC;
      fifo_head_q     <= '0;
      fifo_tail_q     <= '0;
      fifo_count_q    <= '0;
      inflight_head_q <= '0;
      inflight_tail_q <= '0;
      outstanding_q   <= '0;
      discard_q       <= '0;
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      fifo_head_q     <= fifo_head_d;
      fifo_tail_q     <= fifo_tail_d;
      fifo_count_q    <= fifo_count_d;
      inflight_head_q <= inflight_head_d;
      inflight_tail_q <= inflight_tail_d;
      outstanding_q   <= outstanding_d;
      discard_q       <= discard_d;
    end
  end

  // NOTE: the storage arrays are deliberately left without reset; the counts
  // and pointers above decide which slots are live, so stale contents are
  // never observed and the arrays can map onto plain RAM/flop banks.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem_q[fifo_tail_q] <= fifo_wr_data;
    end
    if (grant) begin
      inflight_mem_q[inflight_tail_q] <= fetch_pc_q;
    end
  end

  a_occupancy_bound: assert property (
    @(posedge clk) disable iff (!resetn) occupancy <= DEPTH_OCC);

  a_rvalid_has_request: assert property (
    @(posedge clk) disable iff (!resetn) imem_rvalid |-> (outstanding_q != '0));

  a_no_fifo_overflow: assert property (
    @(posedge clk) disable iff (!resetn)
    !(fifo_push && !fifo_pop && (occ_t'(fifo_count_q) == DEPTH_OCC)));

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Directed bench for instr_prefetch_buffer: a latency-programmable memory model
// feeds the DUT and a scoreboard monitor checks every accepted instruction.
module tb_instr_prefetch_buffer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        resetn;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4_out;

  instr_prefetch_buffer #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_ready  (instr_ready),
    .instr_valid  (instr_valid),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .pc_plus4_out (pc_plus4_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory model: in-order responses, 'lat' cycles after the grant edge.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t mq[$];
  mreq_t mreq_tmp;
  int    cyc;
  int    lat;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      cyc = 0;
      imem_rvalid <= 1'b0;
      imem_rdata  <= 32'h0;
    end else begin
      cyc = cyc + 1;
      if (imem_req && imem_gnt) begin
        mreq_tmp.addr = imem_addr;
        mreq_tmp.due  = cyc + lat - 1;
        mq.push_back(mreq_tmp);
      end
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rvalid <= 1'b0;
        imem_rdata  <= 32'h0;
      end
    end
  end

  // Scoreboard
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = mem_word(pc);
    e.pc4   = pc + 32'd4;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (resetn && instr_valid && instr_ready && !redirect) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected pc_out=0x%08h instr_out=0x%08h expected=none", pc_out, instr_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_pc_out", pc_out, mon_e.pc);
        check("sb_instr_out", instr_out, mon_e.instr);
        check("sb_pc_plus4_out", pc_plus4_out, mon_e.pc4);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n, input int budget);
    int tgt = n_acc + n;
    int k   = 0;
    while (n_acc < tgt && k < budget) begin
      next_cycle();
      k++;
    end
    check("accept_count", n_acc, tgt);
  endtask

  task automatic do_reset();
    check("sb_drained_before_reset", exp_q.size(), 0);
    exp_q.delete();
    resetn = 1'b0;
    #1;
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr_out", instr_out, NOP);
    check("rst_pc_out", pc_out, 32'h0);
    check("rst_pc_plus4_out", pc_plus4_out, 32'h4);
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, 32'h0);
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    next_cycle();
    next_cycle();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 resetn = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    resetn      = 1'b0;
    imem_gnt    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    lat         = 1;
    next_cycle();
    next_cycle();

    // Reset state, then streaming with a 1-cycle memory
    do_reset();
    imem_gnt    = 1'b1;
    instr_ready = 1'b1;
    release_reset();
    check("t1_c0_req", imem_req, 1'b1);
    check("t1_c0_addr", imem_addr, 32'h0);
    check("t1_c0_valid", instr_valid, 1'b0);
    next_cycle();
    check("t1_c1_valid", instr_valid, 1'b0);
    check("t1_c1_addr", imem_addr, 32'h4);
    for (int i = 0; i < 6; i++) push_exp(32'(i * 4));
    next_cycle();
    check("t1_c2_valid", instr_valid, 1'b1);
    check("t1_c2_addr", imem_addr, 32'h8);
    wait_acc(6, 30);
    instr_ready = 1'b0;

    // Stall fill to DEPTH, then drain in order with grants held off
    do_reset();
    instr_ready = 1'b0;
    imem_gnt    = 1'b1;
    release_reset();
    repeat (10) next_cycle();
    check("t2_full_valid", instr_valid, 1'b1);
    check("t2_full_req", imem_req, 1'b0);
    check("t2_full_head_pc", pc_out, 32'h0);
    imem_gnt = 1'b0;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
    instr_ready = 1'b1;
    repeat (8) next_cycle();
    check("t2_drained", exp_q.size(), 0);
    check("t2_empty_valid", instr_valid, 1'b0);
    check("t2_empty_instr", instr_out, NOP);
    check("t2_resume_req", imem_req, 1'b1);
    check("t2_resume_addr", imem_addr, 32'h10);
    imem_gnt = 1'b1;
    push_exp(32'h10); push_exp(32'h14);
    wait_acc(2, 20);
    instr_ready = 1'b0;
    repeat (3) next_cycle();

    // Redirect with two requests in flight (3-cycle memory)
    do_reset();
    lat         = 3;
    instr_ready = 1'b0;
    imem_gnt    = 1'b1;
    release_reset();
    next_cycle();
    imem_gnt = 1'b0;
    next_cycle();
    next_cycle();
    check("t3_c3_valid", instr_valid, 1'b0);
    next_cycle();
    imem_gnt = 1'b1;
    check("t3_c4_valid", instr_valid, 1'b1);
    check("t3_c4_pc", pc_out, 32'h0);
    check("t3_c4_addr", imem_addr, 32'h4);
    next_cycle();
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0102;
    #1 check("t3_redir_req", imem_req, 1'b0);
    next_cycle();
    redirect    = 1'b0;
    instr_ready = 1'b1;
    #1;
    check("t3_flushed_valid", instr_valid, 1'b0);
    check("t3_new_req", imem_req, 1'b1);
    check("t3_new_addr", imem_addr, 32'h100);
    push_exp(32'h100); push_exp(32'h104); push_exp(32'h108);
    wait_acc(3, 40);

    // Back-to-back redirects while streaming: the second target wins
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0202;
    next_cycle();
    redirect_pc = 32'h0000_0300;
    #1;
    check("t3_rd2_addr", imem_addr, 32'h200);
    check("t3_rd2_req", imem_req, 1'b0);
    next_cycle();
    redirect    = 1'b0;
    instr_ready = 1'b1;
    #1 check("t3_rd2_new_addr", imem_addr, 32'h300);
    push_exp(32'h300); push_exp(32'h304); push_exp(32'h308);
    wait_acc(3, 40);
    instr_ready = 1'b0;

    // Address wrap at the top of the 32-bit space
    do_reset();
    lat         = 1;
    instr_ready = 1'b0;
    imem_gnt    = 1'b0;
    release_reset();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    next_cycle();
    redirect    = 1'b0;
    imem_gnt    = 1'b1;
    instr_ready = 1'b1;
    #1;
    check("t4_addr_top", imem_addr, 32'hFFFF_FFFC);
    check("t4_req_top", imem_req, 1'b1);
    push_exp(32'hFFFF_FFFC); push_exp(32'h0); push_exp(32'h4);
    next_cycle();
    check("t4_addr_wrapped", imem_addr, 32'h0);
    wait_acc(3, 20);
    instr_ready = 1'b0;

    // Full FIFO drained while refilling, then an asynchronous reset mid-stream
    do_reset();
    lat         = 1;
    instr_ready = 1'b0;
    imem_gnt    = 1'b1;
    release_reset();
    repeat (8) next_cycle();
    check("t5_full_valid", instr_valid, 1'b1);
    check("t5_full_req", imem_req, 1'b0);
    for (int i = 0; i < 10; i++) push_exp(32'(i * 4));
    instr_ready = 1'b1;
    wait_acc(10, 60);
    instr_ready = 1'b0;
    repeat (4) next_cycle();
    check("t5_pre_reset_valid", instr_valid, 1'b1);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
